start_debouncer: RTL and testbench
==================================

START_DEBOUNCER -- requirements
Module: start_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable clk cycles (10 ms at 50 MHz) required to accept a level change; legal range 2..2^24-1.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1, 1 means btn_in low = pressed (board push-buttons), 0 means high = pressed.
REQ-003 Parameter REPEAT_CYCLES, default 25000000, auto-repeat period in clk cycles; used only under AUTO_REPEAT_EN.
REQ-004 clk  input  1  system clock (FPGA clock, same domain as the clock divider and blinking FSM).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_in  input  1  raw mechanical button, asynchronous to clk, bouncing.
REQ-007 start_pulse  output  1  single-cycle strobe per accepted press; drives the blinking FSM start input.
REQ-008 start_level  output  1  debounced pressed level, active-high regardless of BTN_ACTIVE_LOW.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer, then be polarity-normalised to btn_sync (1 = pressed); no logic SHALL read btn_in directly.
REQ-010 FSM states SHALL be IDLE, DEB_PRESS, PRESSED, DEB_RELEASE; one shared counter cnt, width clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)).
REQ-011 IDLE: btn_sync=1 -> DEB_PRESS with cnt=0; else stay.
REQ-012 DEB_PRESS: btn_sync=0 -> IDLE (bounce rejected, no pulse); btn_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise cnt+1.
REQ-013 Transition DEB_PRESS->PRESSED SHALL register start_pulse=1 for exactly one cycle, coincident with the first PRESSED cycle.
REQ-014 Latency: raw press stable from edge k SHALL yield start_pulse high in the cycle following edge k+DEBOUNCE_CYCLES+3.
REQ-015 PRESSED: btn_sync=0 -> DEB_RELEASE with cnt=0; else stay.
REQ-016 DEB_RELEASE: btn_sync=1 -> PRESSED with no new pulse (release bounce rejected); btn_sync=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-017 start_level SHALL be 1 in PRESSED and DEB_RELEASE, 0 in IDLE and DEB_PRESS, registered.
REQ-018 A press shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no level change.
REQ-019 At most one start_pulse per IDLE->PRESSED excursion (without AUTO_REPEAT_EN); start_pulse SHALL never be high two consecutive cycles.
REQ-020 cnt SHALL never wrap; it saturates at its terminal value because every terminal compare forces a state change.

Reset
REQ-021 reset=1 SHALL asynchronously force state=IDLE, cnt=0, both synchronizer flops to the unpressed level, start_pulse=0, start_level=0.
REQ-022 reset asserted mid-debounce or while PRESSED SHALL discard the press; after release of reset, a held button SHALL re-debounce the full DEBOUNCE_CYCLES before any pulse.
REQ-023 Reset deassertion SHALL be synchronized externally; no pulse SHALL be emitted in the first 2 cycles after reset release.

Configuration
REQ-024 Macro AUTO_REPEAT_EN defined: in PRESSED, cnt counts each cycle; at cnt=REPEAT_CYCLES-1 start_pulse SHALL assert one cycle and cnt reloads to 0, so a held button pulses every REPEAT_CYCLES cycles.
REQ-025 AUTO_REPEAT_EN undefined: cnt holds 0 in PRESSED, REPEAT_CYCLES unused, exactly one pulse per press; no repeat logic synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, BTN_ACTIVE_LOW=1)
REQ-026 btn_in driven 0 at edge 10 and held -> start_pulse=1 only in cycle after edge 17, start_level=1 from same cycle.
REQ-027 btn_in low for 3 cycles then high, repeated 5 times -> start_pulse and start_level stay 0 throughout.
REQ-028 Held press, then 2-cycle high glitch, then low again -> no second pulse, start_level stays 1; release held 4+ synchronized cycles -> start_level=0.
REQ-029 reset pulsed while in DEB_PRESS with btn_in still low -> outputs 0 immediately; first pulse arrives DEBOUNCE_CYCLES+3 edges after reset release.
REQ-030 AUTO_REPEAT_EN defined, button held 40 cycles after acceptance -> pulses at acceptance then every 8 cycles (5 repeats); undefined -> exactly 1 pulse.

Source files
------------

// File: rtl/start_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : start_debouncer
// Purpose  : Debounces a raw mechanical push-button and turns each accepted
//            press into a single-cycle start strobe plus a clean level.
//            The raw input is brought into the clk domain by a 2-flop
//            synchronizer and normalised so that 1 always means "pressed".
//            Optional feature macro: AUTO_REPEAT_EN. When defined, a held
//            button re-emits start_pulse every REPEAT_CYCLES clk cycles.
//
// Ports    : clk          in   system clock
//            reset        in   asynchronous, active-high reset
//            btn_in       in   raw bouncing button, asynchronous to clk
//            start_pulse  out  one-cycle strobe per accepted press
//            start_level  out  debounced pressed level, active-high
//
// Revision : 1.0  initial release
// ============================================================================
module start_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic start_pulse,
  output logic start_level
);

  // Shared counter is wide enough for the longer of the two periods.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_rep_last = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Raw level of an unpressed button; the synchronizer resets to it so that
  // leaving reset never looks like a press edge.
  localparam logic c_btn_idle = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             btn_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  assign btn_sync = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end

      DEB_PRESS: begin
        if (!btn_sync) begin
          // Bounce: drop back without any visible effect.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_deb_last) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!btn_sync) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (cnt_q == c_rep_last) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end

      DEB_RELEASE: begin
        if (btn_sync) begin
          // Release bounce: still pressed, no new strobe.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == c_deb_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the next state so it is registered together with it.
    level_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= c_btn_idle;
      sync2_q <= c_btn_idle;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign start_pulse = pulse_q;
  assign start_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_start_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_start_debouncer
// Purpose  : Self-checking bench for start_debouncer (D=4, R=8, active-low).
//            Reference model: the accepted level flips when the synchronized
//            button has disagreed with it for D+1 consecutive samples; a
//            rising flip yields a strobe; with AUTO_REPEAT_EN a held press
//            strobes every R further samples.
// Revision : 1.0  initial release
// ============================================================================
module tb_start_debouncer;

  localparam int D  = 4;
  localparam int R  = 8;
  localparam int AL = 1;
  localparam logic RAW_DN = (AL != 0) ? 1'b0 : 1'b1;
  localparam logic RAW_UP = (AL != 0) ? 1'b1 : 1'b0;

  logic clk;
  logic reset;
  logic btn_in;
  logic start_pulse;
  logic start_level;

  int checks = 0;
  int passes = 0;

  // reference model state
  bit m_s1, m_s2, m_level, m_pulse, m_prev;
  int m_run, m_hold;

  start_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (AL),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .start_pulse(start_pulse),
    .start_level(start_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit pressed_of(input logic raw);
    return (AL != 0) ? ~raw : raw;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_prev = 0;
    m_run = 0; m_hold = 0;
  endtask

  // One clock edge of the model, given the raw value present before it.
  task automatic model_edge(input logic raw);
    bit sample;
    sample  = m_s2;
    m_s2    = m_s1;
    m_s1    = pressed_of(raw);
    m_pulse = 0;
    if (sample != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = sample;
        m_run   = 0;
        m_hold  = 0;
        if (sample) m_pulse = 1;
      end
    end else begin
      m_run = 0;
`ifdef AUTO_REPEAT_EN
      if (m_level) begin
        if (m_prev) begin
          m_hold++;
          if (m_hold == R) begin
            m_pulse = 1;
            m_hold  = 0;
          end
        end else begin
          m_hold = 0;
        end
      end
`endif
    end
    m_prev = sample;
  endtask

  // Drive one cycle (optionally releasing reset), then sample after the edge.
  task automatic step(input logic raw, input logic deassert);
    @(negedge clk);
    if (deassert) reset = 1'b0;
    btn_in = raw;
    model_edge(raw);
    @(posedge clk);
    #1;
  endtask

  task automatic hit_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = RAW_UP;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_pulse !== 1'b0) $display("FAIL reset_pulse got=%b want=0", start_pulse);
    else passes++;
    checks++;
    if (start_level !== 1'b0) $display("FAIL reset_level got=%b want=0", start_level);
    else passes++;
    for (int n = 0; n < 6; n++) begin
      step(RAW_UP, n == 0);
      checks++;
      if (start_pulse !== m_pulse || start_level !== m_level)
        $display("FAIL reset_idle n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                 n, start_pulse, start_level, m_pulse, m_level);
      else passes++;
    end
  endtask

  task automatic test_latency();
    int first;
    int npulse;
    logic lvl_at_first;
    first = -1; npulse = 0; lvl_at_first = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step(RAW_DN, 1'b0);
      checks++;
      if (start_pulse !== m_pulse || start_level !== m_level)
        $display("FAIL latency n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                 n, start_pulse, start_level, m_pulse, m_level);
      else passes++;
      if (start_pulse === 1'b1) begin
        npulse++;
        if (first < 0) begin
          first = n;
          lvl_at_first = start_level;
        end
      end
    end
    checks++;
    if (first != D + 3) $display("FAIL latency_edge got=%0d want=%0d", first, D + 3);
    else passes++;
    checks++;
    if (lvl_at_first !== 1'b1) $display("FAIL latency_level got=%b want=1", lvl_at_first);
    else passes++;
    checks++;
    if (npulse != 1) $display("FAIL latency_count got=%0d want=1", npulse);
    else passes++;
    for (int n = 0; n < 10; n++) step(RAW_UP, 1'b0);
    checks++;
    if (start_level !== 1'b0) $display("FAIL latency_release got=%b want=0", start_level);
    else passes++;
  endtask

  task automatic test_short_presses();
    int active;
    active = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int n = 0; n < 6; n++) begin
        step((n < 3) ? RAW_DN : RAW_UP, 1'b0);
        checks++;
        if (start_pulse !== m_pulse || start_level !== m_level)
          $display("FAIL short rep=%0d n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                   rep, n, start_pulse, start_level, m_pulse, m_level);
        else passes++;
        if (start_pulse !== 1'b0 || start_level !== 1'b0) active++;
      end
    end
    checks++;
    if (active != 0) $display("FAIL short_activity got=%0d want=0", active);
    else passes++;
  endtask

  task automatic test_glitch();
    int npulse;
    int low_level;
    npulse = 0; low_level = 0;
    for (int n = 1; n <= 20; n++) begin
      step((n == 11 || n == 12) ? RAW_UP : RAW_DN, 1'b0);
      checks++;
      if (start_pulse !== m_pulse || start_level !== m_level)
        $display("FAIL glitch n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                 n, start_pulse, start_level, m_pulse, m_level);
      else passes++;
      if (start_pulse === 1'b1) npulse++;
      if (n >= D + 3 && start_level !== 1'b1) low_level++;
    end
    checks++;
    if (npulse != 1) $display("FAIL glitch_count got=%0d want=1", npulse);
    else passes++;
    checks++;
    if (low_level != 0) $display("FAIL glitch_level_drop got=%0d want=0", low_level);
    else passes++;
    for (int n = 0; n < 8; n++) step(RAW_UP, 1'b0);
    checks++;
    if (start_level !== 1'b0) $display("FAIL glitch_release got=%b want=0", start_level);
    else passes++;
  endtask

  // Press, reset, keep holding, measure edges from reset release to strobe.
  task automatic reset_and_measure(input string tag);
    int first;
    first = -1;
    hit_reset();
    checks++;
    if (start_pulse !== 1'b0 || start_level !== 1'b0)
      $display("FAIL %s_async got pulse=%b level=%b want 0 0", tag, start_pulse, start_level);
    else passes++;
    for (int n = 1; n <= 12; n++) begin
      step(RAW_DN, n == 1);
      checks++;
      if (start_pulse !== m_pulse || start_level !== m_level)
        $display("FAIL %s n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                 tag, n, start_pulse, start_level, m_pulse, m_level);
      else passes++;
      if (start_pulse === 1'b1 && first < 0) first = n;
    end
    checks++;
    if (first != D + 3) $display("FAIL %s_latency got=%0d want=%0d", tag, first, D + 3);
    else passes++;
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 4; n++) step(RAW_DN, 1'b0);   // now debouncing
    reset_and_measure("rst_deb");
    checks++;
    if (start_level !== 1'b1) $display("FAIL rst_pressed_pre got=%b want=1", start_level);
    else passes++;
    reset_and_measure("rst_pressed");
    for (int n = 0; n < 10; n++) step(RAW_UP, 1'b0);
  endtask

  task automatic test_repeat();
    int npulse;
    int guard;
    int want;
`ifdef AUTO_REPEAT_EN
    want = 6;
`else
    want = 1;
`endif
    npulse = 0; guard = 0;
    while (npulse == 0 && guard < 20) begin
      step(RAW_DN, 1'b0);
      guard++;
      if (start_pulse === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 1) $display("FAIL repeat_accept got=%0d want=1", npulse);
    else passes++;
    for (int n = 1; n <= 40; n++) begin
      step(RAW_DN, 1'b0);
      checks++;
      if (start_pulse !== m_pulse || start_level !== m_level)
        $display("FAIL repeat n=%0d got pulse=%b level=%b want pulse=%b level=%b",
                 n, start_pulse, start_level, m_pulse, m_level);
      else passes++;
      if (start_pulse === 1'b1) npulse++;
    end
    checks++;
    if (npulse != want) $display("FAIL repeat_count got=%0d want=%0d", npulse, want);
    else passes++;
    for (int n = 0; n < 10; n++) step(RAW_UP, 1'b0);
  endtask

  task automatic test_random();
    logic prev_p;
    prev_p = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      logic raw;
      int   len;
      bit   rst_now;
      raw     = ($urandom_range(0, 1) == 1) ? RAW_DN : RAW_UP;
      len     = int'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(10, 30));
      rst_now = ($urandom_range(0, 39) == 0);
      if (rst_now) begin
        hit_reset();
        checks++;
        if (start_pulse !== 1'b0 || start_level !== 1'b0)
          $display("FAIL rand_reset seg=%0d got pulse=%b level=%b want 0 0",
                   seg, start_pulse, start_level);
        else passes++;
        prev_p = 1'b0;
      end
      for (int k = 0; k < len; k++) begin
        step(raw, rst_now && (k == 0));
        checks++;
        if (start_pulse !== m_pulse || start_level !== m_level)
          $display("FAIL rand seg=%0d k=%0d got pulse=%b level=%b want pulse=%b level=%b",
                   seg, k, start_pulse, start_level, m_pulse, m_level);
        else passes++;
        checks++;
        if (prev_p === 1'b1 && start_pulse === 1'b1)
          $display("FAIL rand_double seg=%0d k=%0d got pulse=1 twice want single", seg, k);
        else passes++;
        prev_p = start_pulse;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_presses();
    test_glitch();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
